// File: rtl/seg7_scan_decoder.sv
// Display monitor for a multiplexed 4-digit 7-segment bus: rebuilds the shown hex
// value, decimal points and blank flags, publishing one frame per complete scan.
module seg7_scan_decoder #(
  parameter bit          SEG_ACTIVE_LOW = 1'b1,
  parameter bit          SEL_ACTIVE_LOW = 1'b1,
  parameter int unsigned SETTLE_CYCLES  = 2
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [7:0]  i_LED,
  input  logic [3:0]  i_digitSelect,
  output logic [15:0] o_digits,
  output logic [3:0]  o_dp,
  output logic [3:0]  o_blank,
  output logic        o_frame_valid,
  output logic        o_err_glyph,
  output logic        o_err_sel
);

  localparam logic [3:0] SETTLE = 4'(SETTLE_CYCLES);

  logic [7:0]  led_q, led_p;
  logic [3:0]  sel_q, sel_p;
  logic [3:0]  cnt, cnt_nxt;
  logic        sel_none, sel_onehot, sel_multi, pair_changed;
  logic        capture;
  logic        glyph_ok, glyph_blank, glyph_good;
  logic [3:0]  glyph_val;
  logic [3:0]  cap_mask;
  logic [15:0] slot_digits;
  logic [3:0]  slot_dp, slot_blank, seen;

  assign sel_none     = (sel_q == 4'b0000);
  assign sel_onehot   = $onehot(sel_q);
  assign sel_multi    = !sel_none && !sel_onehot;
  assign pair_changed = ({led_q, sel_q} != {led_p, sel_p});

  // NOTE: every signal driven here gets a default first so no path leaves it unassigned (no latches).
  always_comb begin
    glyph_ok  = 1'b1;
    glyph_val = 4'h0;
    case (led_q[6:0])
      7'h3F: glyph_val = 4'h0;
      7'h06: glyph_val = 4'h1;
      7'h5B: glyph_val = 4'h2;
      7'h4F: glyph_val = 4'h3;
      7'h66: glyph_val = 4'h4;
      7'h6D: glyph_val = 4'h5;
      7'h7D: glyph_val = 4'h6;
      7'h07: glyph_val = 4'h7;
      7'h7F: glyph_val = 4'h8;
      7'h6F: glyph_val = 4'h9;
      7'h77: glyph_val = 4'hA;
      7'h7C: glyph_val = 4'hB;
      7'h39: glyph_val = 4'hC;
      7'h5E: glyph_val = 4'hD;
      7'h79: glyph_val = 4'hE;
      7'h71: glyph_val = 4'hF;
      default: glyph_ok = 1'b0;
    endcase
  end

  assign glyph_blank = (led_q[6:0] == 7'h00);
  assign glyph_good  = glyph_ok || glyph_blank;

  always_comb begin
    cnt_nxt = cnt;
    if (!sel_onehot)
      cnt_nxt = 4'd0;
    else if (pair_changed)
      cnt_nxt = 4'd1;
    else if (cnt < SETTLE)
      cnt_nxt = cnt + 4'd1;
  end

  // One capture per dwell: only on the edge where the count arrives at SETTLE.
  assign capture  = sel_onehot && (cnt_nxt == SETTLE) && (pair_changed || cnt != SETTLE);
  assign cap_mask = (capture && glyph_good) ? sel_q : 4'b0000;

  // NOTE: sequential state uses non-blocking assignments only; the small slot registers are reset too.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      led_q         <= '0;
      sel_q         <= '0;
      led_p         <= '0;
      sel_p         <= '0;
      cnt           <= '0;
      slot_digits   <= '0;
      slot_dp       <= '0;
      slot_blank    <= '0;
      seen          <= '0;
      o_digits      <= '0;
      o_dp          <= '0;
      o_blank       <= '0;
      o_frame_valid <= 1'b0;
      o_err_glyph   <= 1'b0;
      o_err_sel     <= 1'b0;
    end else begin
      led_q <= SEG_ACTIVE_LOW ? ~i_LED : i_LED;
      sel_q <= SEL_ACTIVE_LOW ? ~i_digitSelect : i_digitSelect;
      led_p <= led_q;
      sel_p <= sel_q;
      cnt   <= cnt_nxt;

      for (int i = 0; i < 4; i++) begin
        if (cap_mask[i]) begin
          slot_digits[4*i +: 4] <= glyph_blank ? 4'h0 : glyph_val;
          slot_blank[i]         <= glyph_blank;
          slot_dp[i]            <= led_q[7];
        end
      end

      if (capture && !glyph_good) o_err_glyph <= 1'b1;
      if (sel_multi)              o_err_sel   <= 1'b1;

      o_frame_valid <= 1'b0;
      if (seen == 4'b1111) begin
        o_digits      <= slot_digits;
        o_dp          <= slot_dp;
        o_blank       <= slot_blank;
        o_frame_valid <= 1'b1;
        seen          <= cap_mask;
      end else begin
        seen <= seen | cap_mask;
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Randomised scan stimulus for seg7_scan_decoder; expected frames are queued by the
// stimulus and checked by an independent monitor on every o_frame_valid pulse.
module tb_seg7_scan_decoder;

  typedef struct packed {
    logic [15:0] d;
    logic [3:0]  dp;
    logic [3:0]  bl;
  } frame_t;

  logic        clk = 1'b0;
  logic        i_rst = 1'b1;
  logic [7:0]  i_LED = 8'hFF;
  logic [3:0]  i_digitSelect = 4'hF;
  logic [15:0] o_digits;
  logic [3:0]  o_dp, o_blank;
  logic        o_frame_valid, o_err_glyph, o_err_sel;

  int     n_vec  = 0;
  int     n_miss = 0;
  frame_t exp_q[$];

  logic [6:0] glyph [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                             7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  seg7_scan_decoder dut (
    .i_clk(clk), .i_rst(i_rst), .i_LED(i_LED), .i_digitSelect(i_digitSelect),
    .o_digits(o_digits), .o_dp(o_dp), .o_blank(o_blank), .o_frame_valid(o_frame_valid),
    .o_err_glyph(o_err_glyph), .o_err_sel(o_err_sel)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every published frame must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!i_rst && o_frame_valid) begin
      check("frame_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        frame_t e;
        e = exp_q.pop_front();
        check("frame_digits", 32'(o_digits), 32'(e.d));
        check("frame_dp",     32'(o_dp),     32'(e.dp));
        check("frame_blank",  32'(o_blank),  32'(e.bl));
      end
    end
  end

  // Drives logical (active-high) values onto the active-low bus for n cycles.
  task automatic hold(input logic [7:0] seg, input logic [3:0] sel, input int n);
    i_LED         = ~seg;
    i_digitSelect = ~sel;
    repeat (n) @(negedge clk);
  endtask

  task automatic scan_digit(input int d, input logic [3:0] v, input logic dp,
                            input logic bl, input bit glitch);
    logic [7:0] pat;
    logic [3:0] sel;
    pat = {dp, bl ? 7'h00 : glyph[v]};
    sel = 4'(1 << d);
    hold(pat, sel, $urandom_range(2, 5));
    if (glitch) begin
      hold(8'h00, sel, 1);
      hold(pat, sel, 2);
    end
    hold(8'h00, 4'h0, $urandom_range(0, 2));
  endtask

  task automatic scan_frame(input frame_t f, input bit glitch);
    frame_t e;
    e = f;
    for (int i = 0; i < 4; i++) if (f.bl[i]) e.d[4*i +: 4] = 4'h0;
    exp_q.push_back(e);
    for (int i = 0; i < 4; i++)
      scan_digit(i, f.d[4*i +: 4], f.dp[i], f.bl[i], glitch && (i == 2));
  endtask

  function automatic frame_t rand_frame();
    frame_t f;
    f.d  = 16'($urandom);
    f.dp = 4'($urandom);
    for (int i = 0; i < 4; i++) f.bl[i] = ($urandom_range(0, 5) == 0);
    return f;
  endfunction

  task automatic check_all_zero(input string tag);
    check({tag, "_digits"}, 32'(o_digits), 32'd0);
    check({tag, "_dp"},     32'(o_dp), 32'd0);
    check({tag, "_blank"},  32'(o_blank), 32'd0);
    check({tag, "_valid"},  32'(o_frame_valid), 32'd0);
    check({tag, "_eglyph"}, 32'(o_err_glyph), 32'd0);
    check({tag, "_esel"},   32'(o_err_sel), 32'd0);
  endtask

  initial begin
    frame_t f;
    repeat (3) @(negedge clk);
    i_rst = 1'b0;
    check_all_zero("reset");

    // Count-up: 0000 then 0001.
    scan_frame('{d: 16'h0000, dp: 4'h0, bl: 4'h0}, 1'b0);
    scan_frame('{d: 16'h0001, dp: 4'h0, bl: 4'h0}, 1'b0);
    scan_frame('{d: 16'h4321, dp: 4'h0, bl: 4'h0}, 1'b1);

    for (int k = 0; k < 25; k++) scan_frame(rand_frame(), ($urandom_range(0, 2) == 0));

    // Blank digit 3, digit 0 shows 8 with its decimal point.
    scan_frame('{d: 16'h5678, dp: 4'b0001, bl: 4'b1000}, 1'b0);
    check("no_glyph_err", 32'(o_err_glyph), 32'd0);
    check("no_sel_err",   32'(o_err_sel), 32'd0);

    // Illegal glyph on digit 0: flagged, digit stays unseen.
    hold(8'h01, 4'b0001, 4);
    hold(8'h00, 4'h0, 1);
    check("err_glyph_set", 32'(o_err_glyph), 32'd1);
    check("err_sel_clear", 32'(o_err_sel), 32'd0);
    scan_digit(1, 4'hA, 1'b0, 1'b0, 1'b0);
    scan_digit(2, 4'hB, 1'b0, 1'b0, 1'b0);
    scan_digit(3, 4'hC, 1'b0, 1'b0, 1'b0);
    hold(8'h00, 4'h0, 4);
    exp_q.push_back('{d: 16'hCBA5, dp: 4'h0, bl: 4'h0});
    scan_digit(0, 4'h5, 1'b0, 1'b0, 1'b0);

    // Multi-hot select: flagged, nothing captured.
    hold(8'h06, 4'b0011, 3);
    hold(8'h00, 4'h0, 1);
    check("err_sel_set",    32'(o_err_sel), 32'd1);
    check("err_glyph_held", 32'(o_err_glyph), 32'd1);
    scan_frame(rand_frame(), 1'b0);
    check("err_sel_sticky", 32'(o_err_sel), 32'd1);

    // Reset mid-frame discards digits 0 and 1.
    scan_digit(0, 4'h7, 1'b1, 1'b0, 1'b0);
    scan_digit(1, 4'h3, 1'b1, 1'b0, 1'b0);
    i_rst = 1'b1;
    repeat (2) @(negedge clk);
    i_rst = 1'b0;
    check_all_zero("midreset");
    scan_digit(2, 4'h2, 1'b1, 1'b0, 1'b0);
    scan_digit(3, 4'h0, 1'b0, 1'b1, 1'b0);
    hold(8'h00, 4'h0, 4);
    exp_q.push_back('{d: 16'h02E9, dp: 4'b0110, bl: 4'b1000});
    scan_digit(0, 4'h9, 1'b0, 1'b0, 1'b0);
    scan_digit(1, 4'hE, 1'b1, 1'b0, 1'b0);

    for (int k = 0; k < 3; k++) scan_frame(rand_frame(), 1'b0);

    for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(negedge clk);
    check("pending_frames", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
